// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and constants for the pc_fetch sequencer
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam int PC_W     = 10;
    localparam int PC_START = 0;
    localparam int CYC_W    = 16;

    // Saturating increment for the performance counter.
    function automatic logic [CYC_W-1:0] cyc_sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - control/branch inputs and PC/status outputs of pc_fetch (PC_FETCH_CYCLE_CNT_EN adds cycle_cnt)
interface pc_fetch_if #(
    parameter int D = pc_pkg::PC_W
);
    import pc_pkg::*;

    logic         start;
    logic         stall;
    logic         halt;
    logic         branch_en;
    logic         branch_taken;
    logic         jump_abs;
    logic [D-1:0] target;
    logic [D-1:0] prog_ctr;
    logic         running;
    logic         done;
`ifdef PC_FETCH_CYCLE_CNT_EN
    logic [CYC_W-1:0] cycle_cnt;

    modport master (
        output start, stall, halt, branch_en, branch_taken, jump_abs, target,
        input  prog_ctr, running, done, cycle_cnt
    );
    modport slave (
        input  start, stall, halt, branch_en, branch_taken, jump_abs, target,
        output prog_ctr, running, done, cycle_cnt
    );
`else
    modport master (
        output start, stall, halt, branch_en, branch_taken, jump_abs, target,
        input  prog_ctr, running, done
    );
    modport slave (
        input  start, stall, halt, branch_en, branch_taken, jump_abs, target,
        output prog_ctr, running, done
    );
`endif

endinterface

// File: rtl/pc_fetch_next_calc.sv
// rtl/pc_fetch_next_calc.sv - next-PC arithmetic: sequential, absolute jump or PC-relative branch
module pc_next_calc
    import pc_pkg::*;
#(
    parameter int D = PC_W
) (
    input  logic [D-1:0] i_pc,
    input  logic [D-1:0] i_target,
    input  logic         i_jump_abs,
    input  logic         i_take,
    output logic [D-1:0] o_next_pc
);

    logic [D-1:0] w_seq_pc;
    logic [D-1:0] w_rel_pc;

    // D-bit truncation makes two's-complement offsets and 0x3FF+1 wrap for free.
    assign w_seq_pc = i_pc + D'(1);
    assign w_rel_pc = i_pc + i_target;

    always_comb begin
        o_next_pc = w_seq_pc;
        if (i_take) begin
            o_next_pc = i_jump_abs ? i_target : w_rel_pc;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and IDLE/RUN/DONE fetch sequencer (PC_FETCH_CYCLE_CNT_EN adds cycle_cnt)
module pc_fetch
    import pc_pkg::*;
#(
    parameter int           D          = PC_W,
    parameter logic [D-1:0] START_ADDR = D'(PC_START)
) (
    input  logic     clk,
    input  logic     reset_n,
    pc_fetch_if.slave bus
);

    fetch_state_t r_state;
    logic [D-1:0] r_pc;
    logic         r_running;
    logic         r_done;
    logic [D-1:0] w_next_pc;
    logic         w_take;
`ifdef PC_FETCH_CYCLE_CNT_EN
    logic [CYC_W-1:0] r_cyc_cnt;
`endif

    assign w_take = bus.branch_en & bus.branch_taken;

    pc_next_calc #(.D(D)) u_next (
        .i_pc       (r_pc),
        .i_target   (bus.target),
        .i_jump_abs (bus.jump_abs),
        .i_take     (w_take),
        .o_next_pc  (w_next_pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
`ifdef PC_FETCH_CYCLE_CNT_EN
            r_cyc_cnt <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state   <= RUN;
                        r_pc      <= START_ADDR;
                        r_running <= 1'b1;
                        r_done    <= 1'b0;
`ifdef PC_FETCH_CYCLE_CNT_EN
                        r_cyc_cnt <= '0;
`endif
                    end
                end
                RUN: begin
                    // A stalled cycle drops any halt/branch; the decoder re-presents it.
                    if (!bus.stall) begin
`ifdef PC_FETCH_CYCLE_CNT_EN
                        r_cyc_cnt <= cyc_sat_inc(r_cyc_cnt);
`endif
                        if (bus.halt) begin
                            r_state   <= DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prog_ctr = r_pc;
    assign bus.running  = r_running;
    assign bus.done     = r_done;
`ifdef PC_FETCH_CYCLE_CNT_EN
    assign bus.cycle_cnt = r_cyc_cnt;
`endif

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Program counter and fetch sequencer for the 10-bit instruction memory.
- Sits directly downstream of the branch-target lookup table. Takes the looked-up target and a branch/jump decision, and produces the next instruction address.
- Also owns the start/run/done control of the processor, so the top level sees a clean done flag.

Parameters:
- D, 10, program counter / instruction address width.
- START_ADDR, 0, PC value loaded on each start.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; launches a program run from IDLE or DONE.
- stall  input  1  freeze the PC and state for this cycle while in RUN.
- halt  input  1  decoded halt/end instruction at the current PC.
- branch_en  input  1  current instruction is a branch/jump.
- branch_taken  input  1  branch condition is true.
- jump_abs  input  1  1: target is an absolute address; 0: target is a signed PC-relative offset.
- target  input  D  target value from the branch-target lookup table.
- prog_ctr  output  D  current instruction address; registered.
- running  output  1  high while in RUN.
- done  output  1  high in DONE; held until the next start or reset.

Behaviour:
- Reset:
  - Async assert of reset_n clears everything immediately: state=IDLE, prog_ctr=0, running=0, done=0.
  - Deassertion is synchronised externally. A reset mid-run abandons the run with no residue.
- FSM states: IDLE, RUN, DONE. Outputs are registered, decoded from the state register: running=(state==RUN), done=(state==DONE).
- IDLE:
  - prog_ctr holds.
  - start=1 -> prog_ctr<=START_ADDR and state<=RUN. The first fetch address is visible the cycle after start.
  - All other inputs are ignored.
- RUN, priority highest first:
  1. stall=1: prog_ctr and state hold. A halt or branch asserted in the same cycle is ignored and must be re-presented.
  2. halt=1: state<=DONE; prog_ctr holds (points at the halt instruction).
  3. branch_en=1 and branch_taken=1, jump_abs=1: prog_ctr<=target.
  4. branch_en=1 and branch_taken=1, jump_abs=0: prog_ctr<=(prog_ctr+target) mod 2^D. target is two's complement, so 0x3FB means -5 when D=10.
  5. Otherwise, including branch_en=1 with branch_taken=0: prog_ctr<=prog_ctr+1 mod 2^D.
  - start is ignored in RUN.
- Latency: one cycle from inputs to the new prog_ctr. There is no branch delay slot. The instruction at the new address is fetched in the following cycle.
- Wrap-around: 0x3FF+1 -> 0x000. Relative overflow/underflow wraps silently and is never flagged.
- DONE:
  - done=1 and prog_ctr hold.
  - start=1 -> prog_ctr<=START_ADDR, state<=RUN, done drops on the same edge.
- Arithmetic: target and prog_ctr are both D bits, and the sum is truncated to D bits. No sign extension beyond D.

Optional Feature:
- Macro: PC_FETCH_CYCLE_CNT_EN.
- Defined:
  - Adds output cycle_cnt [15:0], counting RUN cycles that are not stalled.
  - Cleared to 0 on reset and on each accepted start.
  - Saturates at 0xFFFF.
  - Frozen in DONE, readable for performance checks.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package pc_pkg:
  - state enum fetch_state_t {IDLE, RUN, DONE}.
  - localparam PC_W=10 (the default for D).
  - localparam PC_START=0.
  - localparam CYC_W=16.
- One natural combinational sub-module, pc_next_calc: takes prog_ctr, target, jump_abs and take and returns next_pc. This isolates the wrap and relative arithmetic so it can be checked standalone.
- The FSM and registers stay in pc_fetch.

Test Plan:
- Reset, then start pulse with START_ADDR=0, no branches -> prog_ctr 0,1,2,3 on successive cycles; running=1, done=0.
- At prog_ctr=5, branch_en=1, branch_taken=1, jump_abs=1, target=80 -> prog_ctr=80 next cycle. Same with branch_taken=0 -> prog_ctr=6.
- At prog_ctr=20, jump_abs=0, target=0x3FB -> prog_ctr=15. At prog_ctr=4, target=0x3FF -> 3. At prog_ctr=0x3FF with no branch -> 0x000.
- stall=1 for 3 cycles at prog_ctr=9 with halt and a taken branch also asserted -> prog_ctr stays 9, state stays RUN. After stall drops, re-presented halt -> done=1 next cycle, prog_ctr=9 held; a start pulse -> prog_ctr=START_ADDR, done=0.
- reset_n driven low mid-run at prog_ctr=119, asynchronously between clock edges -> prog_ctr=0, running=0, done=0 immediately. With the macro defined, cycle_cnt=0.
- With PC_FETCH_CYCLE_CNT_EN: 10 RUN cycles including 2 stalls, then halt -> cycle_cnt=8, held through DONE, cleared on the next start.
